// File: rtl/tensor_result_serializer.sv
// Double-buffered serializer: one 4x4x32 D tile per handshake in, ROWS_PER_BEAT rows per beat out.
// Optional TENSOR_SER_PERF_EN adds perf_tiles / perf_stalls counters.

`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tensor_result_serializer #(
    parameter int ROWS_PER_BEAT = 1,
    parameter int WID_WIDTH     = `NW_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid_in,
    output logic                               ready_in,
    input  logic [3:0][3:0][31:0]              D_tile,
    input  logic [WID_WIDTH-1:0]               D_wid,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic [ROWS_PER_BEAT-1:0][3:0][31:0] data_out,
    output logic [WID_WIDTH-1:0]               wid_out,
    output logic [1:0]                         beat_idx,
    output logic                               last_out
`ifdef TENSOR_SER_PERF_EN
    ,
    output logic [31:0]                        perf_tiles,
    output logic [31:0]                        perf_stalls
`endif
);

    localparam int         BEATS     = 4 / ROWS_PER_BEAT;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    if (!(ROWS_PER_BEAT == 1 || ROWS_PER_BEAT == 2 || ROWS_PER_BEAT == 4)) begin : g_bad_rows_per_beat
        $error("tensor_result_serializer: ROWS_PER_BEAT must be 1, 2 or 4");
    end

    logic [3:0][3:0][31:0]  r_act_tile;
    logic [WID_WIDTH-1:0]   r_act_wid;
    logic                   r_act_valid;
    logic [1:0]             r_beat;
    logic [3:0][3:0][31:0]  r_skid_tile;
    logic [WID_WIDTH-1:0]   r_skid_wid;
    logic                   r_skid_valid;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last;
    logic                   w_free;
    logic                   w_skid_wr;
    logic [1:0]             w_row_base;

    assign ready_in   = !r_skid_valid;
    assign w_in_fire  = valid_in && ready_in;
    assign valid_out  = r_act_valid;
    assign w_last     = r_act_valid && (r_beat == LAST_BEAT);
    assign last_out   = w_last;
    assign w_out_fire = valid_out && ready_out;
    // Active slot frees either when empty or as its final beat leaves this cycle.
    assign w_free     = !r_act_valid || (w_out_fire && w_last);
    assign w_skid_wr  = w_in_fire && (!w_free || r_skid_valid);
    assign wid_out    = r_act_wid;
    assign beat_idx   = r_beat;
    assign w_row_base = 2'(32'(r_beat) * ROWS_PER_BEAT);

    for (genvar r = 0; r < ROWS_PER_BEAT; r++) begin : g_row
        assign data_out[r] = r_act_tile[w_row_base + 2'(r)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the tile registers are reset too so data_out reads zero after reset, not stale rows.
            r_act_tile   <= '0;
            r_act_wid    <= '0;
            r_act_valid  <= 1'b0;
            r_beat       <= '0;
            r_skid_tile  <= '0;
            r_skid_wid   <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_free) begin
            r_beat <= '0;
            if (r_skid_valid) begin
                r_act_valid  <= 1'b1;
                r_act_tile   <= r_skid_tile;
                r_act_wid    <= r_skid_wid;
                r_skid_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_skid_tile <= D_tile;
                    r_skid_wid  <= D_wid;
                end
            end else begin
                r_act_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_act_tile <= D_tile;
                    r_act_wid  <= D_wid;
                end
            end
        end else begin
            if (w_out_fire) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_tile  <= D_tile;
                r_skid_wid   <= D_wid;
            end
        end
    end

`ifdef TENSOR_SER_PERF_EN
    logic [31:0] r_perf_tiles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_tiles  <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_out_fire && w_last) begin
                r_perf_tiles <= r_perf_tiles + 32'd1;
            end
            if (valid_out && !ready_out) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_tiles  = r_perf_tiles;
    assign perf_stalls = r_perf_stalls;
`endif

    a_no_skid_overwrite: assert property (@(posedge clk) disable iff (reset) !(r_skid_valid && w_skid_wr))
        else $error("tensor_result_serializer: skid entry overwritten while valid");

endmodule
